// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-RAM arbiter.
// Requester ids double as the round-robin history value.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of read-owner tags that tracks each RAM read until its data
// appears. The output tag lines up with ram_dout of the matching read.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic id_i,
  output logic valid_o,
  output logic id_o
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = '{valid: valid_i, id: id_i};
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Reset drops every in-flight tag so discarded reads never raise rvalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign valid_o = pipe_q[DEPTH-1].valid;
  assign id_o    = pipe_q[DEPTH-1].id;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the control
// unit (m0) and the debug/loader master (m1), with tagged read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic              last_id_q, last_id_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              gnt0, gnt1;
  logic              push_valid, push_id;
  logic              tag_valid, tag_id;

  // Under contention the master not granted last time wins; a lone requester
  // always wins, so a continuously requesting master waits at most one cycle.
  always_comb begin
    gnt0 = !rst && m0_req && (!m1_req || (last_id_q == ID_M1));
    gnt1 = !rst && m1_req && (!m0_req || (last_id_q == ID_M0));

    last_id_d  = last_id_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (gnt0) begin
      last_id_d  = ID_M0;
      ram_we_d   = m0_we;
      ram_addr_d = m0_addr;
      ram_din_d  = m0_wdata;
    end else if (gnt1) begin
      last_id_d  = ID_M1;
      ram_we_d   = m1_we;
      ram_addr_d = m1_addr;
      ram_din_d  = m1_wdata;
    end

    push_valid = (gnt0 && !m0_we) || (gnt1 && !m1_we);
    push_id    = gnt1 ? ID_M1 : ID_M0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q  <= ID_M1;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      last_id_q  <= last_id_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  // One extra stage covers the cycle spent in the registered RAM command.
  rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (push_valid),
    .id_i    (push_id),
    .valid_o (tag_valid),
    .id_o    (tag_id)
  );

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = !rst && tag_valid && (tag_id == ID_M0);
  assign m1_rvalid = !rst && tag_valid && (tag_id == ID_M1);
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule
